// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel
// double-buffered duty compare, edge- or center-aligned modulation.
module pwm_multi #(
  parameter int WIDTH = 11,
  parameter int CH    = 2,
  parameter int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [CH-1:0]    pwm_sig,
  output logic             pwm_synch,
  output logic             mode_act
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_step;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir;
  logic             dir_step;
  logic             dir_nxt;
  logic             period_end;
  logic             load;
  logic [CH-1:0]    sig_nxt;
  logic [WIDTH-1:0] shadow [CH];
  logic [WIDTH-1:0] active [CH];

  // dir flips on arrival at an end point, so the period boundary
  // (down, cnt==1) naturally steps to cnt=0 going up in both modes.
  always_comb begin
    period_end = mode_act ? (dir && (cnt == ONE)) : (cnt == MAX);
    if (mode_act) begin
      cnt_step = dir ? (cnt - ONE) : (cnt + ONE);
      if (cnt_step == MAX) begin
        dir_step = 1'b1;
      end else if (cnt_step == '0) begin
        dir_step = 1'b0;
      end else begin
        dir_step = dir;
      end
    end else begin
      cnt_step = cnt + ONE;
      dir_step = 1'b0;
    end
    load    = !en || period_end;
    cnt_nxt = cnt_step;
    dir_nxt = dir_step;
    if (!en || (period_end && (mode != mode_act))) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end
  end

  always_comb begin
    sig_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      sig_nxt[i] = en && (cnt < active[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir      <= 1'b0;
      mode_act <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
      if (load) begin
        mode_act <= mode;
      end
    end
  end

  // Out-of-range channel numbers match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_en && (wr_ch == CHW'(i))) begin
          shadow[i] <= wr_duty;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        active[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < CH; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_sig   <= '0;
      pwm_synch <= 1'b0;
    end else begin
      pwm_sig   <= sig_nxt;
      pwm_synch <= en && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (WIDTH=4, CH=3): directed period/duty checks with
// spec-derived constants plus a randomized run against a period-phase model.
module tb_pwm_multi;

  localparam int WIDTH = 4;
  localparam int CH    = 3;
  localparam int CHW   = 2;
  localparam int MAX   = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic             wr_en = 1'b0;
  logic [CHW-1:0]   wr_ch = '0;
  logic [WIDTH-1:0] wr_duty = '0;
  logic [CH-1:0]    pwm_sig;
  logic             pwm_synch;
  logic             mode_act;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position within the current period plus buffered duties.
  int            m_phase;
  logic          m_mode;
  int            m_shadow [CH];
  int            m_active [CH];
  logic [CH-1:0] m_sig;
  logic          m_synch;

  pwm_multi #(.WIDTH(WIDTH), .CH(CH), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .pwm_sig(pwm_sig),
    .pwm_synch(pwm_synch), .mode_act(mode_act)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_phase = 0;
    m_mode  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_sig   = '0;
    m_synch = 1'b0;
  endtask

  task automatic tick();
    int per;
    int c;
    int old_sh [CH];
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      per = m_mode ? 2 * MAX : MAX + 1;
      c   = (m_phase <= MAX) ? m_phase : 2 * MAX - m_phase;
      for (int i = 0; i < CH; i++) m_sig[i] = en && (c < m_active[i]);
      m_synch = en && (c == 0);
      old_sh = m_shadow;
      if (wr_en && (int'(wr_ch) < CH)) m_shadow[wr_ch] = int'(wr_duty);
      if (!en) begin
        m_phase  = 0;
        m_active = old_sh;
        m_mode   = mode;
      end else if (m_phase == per - 1) begin
        m_phase  = 0;
        m_active = old_sh;
        m_mode   = mode;
      end else begin
        m_phase++;
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = CHW'(ch);
    wr_duty = WIDTH'(duty);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_synch(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (pwm_synch) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Starts on a synch cycle, counts n output cycles, ends n cycles later.
  task automatic count_period(input int n, output int h0, output int h1,
                              output int h2, output int hs, output logic [31:0] pat);
    h0 = 0; h1 = 0; h2 = 0; hs = 0; pat = '0;
    for (int j = 0; j < n; j++) begin
      h0 += int'(pwm_sig[0]);
      h1 += int'(pwm_sig[1]);
      h2 += int'(pwm_sig[2]);
      hs += int'(pwm_synch);
      pat[j] = pwm_sig[0];
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    n_cmp++; if (pwm_sig !== 3'b000) begin n_bad++; $display("FAIL reset_sig: got %b want 000", pwm_sig); end
    n_cmp++; if (pwm_synch !== 1'b0) begin n_bad++; $display("FAIL reset_synch: got %b want 0", pwm_synch); end
    n_cmp++; if (mode_act !== 1'b0) begin n_bad++; $display("FAIL reset_mode_act: got %b want 0", mode_act); end
    rst_n = 1'b1;
  endtask

  task automatic test_edge();
    int h0, h1, h2, hs;
    logic [31:0] pat;
    wr(0, 5);
    wr(1, 12);
    wr(2, 0);
    tick();
    en = 1'b1;
    tick();
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL edge_first_synch: got %b want 1", pwm_synch); end
    n_cmp++; if (pwm_sig !== 3'b011) begin n_bad++; $display("FAIL edge_rise_at_synch: got %b want 011", pwm_sig); end
    for (int p = 0; p < 2; p++) begin
      count_period(16, h0, h1, h2, hs, pat);
      n_cmp++; if (h0 !== 5) begin n_bad++; $display("FAIL edge_ch0_high p%0d: got %0d want 5", p, h0); end
      n_cmp++; if (h1 !== 12) begin n_bad++; $display("FAIL edge_ch1_high p%0d: got %0d want 12", p, h1); end
      n_cmp++; if (h2 !== 0) begin n_bad++; $display("FAIL edge_ch2_high p%0d: got %0d want 0", p, h2); end
      n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL edge_synch_count p%0d: got %0d want 1", p, hs); end
    end
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL edge_period16: got %b want 1", pwm_synch); end
  endtask

  task automatic test_duty_write();
    int h [4];
    int want [4];
    want = '{5, 9, 9, 3};
    for (int k = 0; k < 4; k++) h[k] = 0;
    // Write 9 at cnt=7 in period 0; write 3 on the period_end cycle of period 1.
    for (int j = 0; j < 64; j++) begin
      h[j / 16] += int'(pwm_sig[0]);
      wr_en   = ((j < 16) && (m_phase == 7)) || ((j >= 16) && (j < 32) && (m_phase == MAX));
      wr_ch   = '0;
      wr_duty = (j < 16) ? WIDTH'(9) : WIDTH'(3);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (h[k] !== want[k]) begin n_bad++; $display("FAIL duty_write_p%0d: got %0d want %0d", k, h[k], want[k]); end
    end
  endtask

  task automatic test_mode_switch();
    int n;
    int guard;
    guard = 0;
    while (m_phase != 7 && guard < 40) begin tick(); guard++; end
    mode = 1'b1;
    n = 0;
    while (mode_act !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL mode_switch_latency: got %0d want 9", n); end
    tick();
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL mode_switch_restart: got %b want 1", pwm_synch); end
    n = 0;
    do begin tick(); n++; end while (pwm_synch !== 1'b1 && n < 40);
    n_cmp++; if (n !== 30) begin n_bad++; $display("FAIL center_period: got %0d want 30", n); end
  endtask

  task automatic test_center();
    int h0, h1, h2, hs;
    logic [31:0] pat;
    logic [31:0] want_pat;
    bit ok;
    want_pat = 32'h3C00_001F;
    wr(0, 5);
    wr(1, 15);
    wr(2, 0);
    wait_synch(40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL center_wait1: got timeout want synch"); end
    wait_synch(40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL center_wait2: got timeout want synch"); end
    count_period(30, h0, h1, h2, hs, pat);
    n_cmp++; if (h0 !== 9) begin n_bad++; $display("FAIL center_ch0_high: got %0d want 9", h0); end
    n_cmp++; if (h1 !== 29) begin n_bad++; $display("FAIL center_ch1_high: got %0d want 29", h1); end
    n_cmp++; if (h2 !== 0) begin n_bad++; $display("FAIL center_ch2_high: got %0d want 0", h2); end
    n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL center_synch_count: got %0d want 1", hs); end
    n_cmp++; if (pat !== want_pat) begin n_bad++; $display("FAIL center_ch0_shape: got %h want %h", pat, want_pat); end
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL center_next_synch: got %b want 1", pwm_synch); end
  endtask

  task automatic test_enable();
    int h0, h1, h2, hs;
    logic [31:0] pat;
    for (int k = 0; k < 4; k++) tick();
    en = 1'b0;
    tick();
    n_cmp++; if (pwm_sig !== 3'b000) begin n_bad++; $display("FAIL en_low_sig: got %b want 000", pwm_sig); end
    n_cmp++; if (pwm_synch !== 1'b0) begin n_bad++; $display("FAIL en_low_synch: got %b want 0", pwm_synch); end
    mode = 1'b0;
    tick();
    n_cmp++; if (mode_act !== 1'b0) begin n_bad++; $display("FAIL en_low_mode_follow: got %b want 0", mode_act); end
    wr(0, 6);
    wr(1, 10);
    wr(2, 2);
    wr(3, 13);
    tick();
    en = 1'b1;
    tick();
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL en_rise_synch: got %b want 1", pwm_synch); end
    count_period(16, h0, h1, h2, hs, pat);
    n_cmp++; if (h0 !== 6) begin n_bad++; $display("FAIL oor_ch0_high: got %0d want 6", h0); end
    n_cmp++; if (h1 !== 10) begin n_bad++; $display("FAIL oor_ch1_high: got %0d want 10", h1); end
    n_cmp++; if (h2 !== 2) begin n_bad++; $display("FAIL oor_ch2_high: got %0d want 2", h2); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    mode = 1'b1;
    n = 0;
    while (mode_act !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (mode_act !== 1'b1) begin n_bad++; $display("FAIL rst_mid_center: got %b want 1", mode_act); end
    wait_synch(40, ok);
    tick();
    n_cmp++; if (pwm_sig[1] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pulse: got %b want 1", pwm_sig[1]); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (pwm_sig !== 3'b000) begin n_bad++; $display("FAIL rst_mid_sig: got %b want 000", pwm_sig); end
    n_cmp++; if (pwm_synch !== 1'b0) begin n_bad++; $display("FAIL rst_mid_synch: got %b want 0", pwm_synch); end
    n_cmp++; if (mode_act !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mode_act: got %b want 0", mode_act); end
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1'b0;
    tick();
    n_cmp++; if (pwm_synch !== 1'b1) begin n_bad++; $display("FAIL rst_restart_synch: got %b want 1", pwm_synch); end
    n_cmp++; if (pwm_sig !== 3'b000) begin n_bad++; $display("FAIL rst_restart_sig: got %b want 000", pwm_sig); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 900; j++) begin
      en      = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 119) == 0) mode = ~mode;
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = CHW'($urandom_range(0, 3));
      wr_duty = WIDTH'($urandom);
      tick();
      n_cmp++;
      if ({pwm_sig, pwm_synch, mode_act} !== {m_sig, m_synch, m_mode}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got sig=%b synch=%b mode_act=%b want sig=%b synch=%b mode_act=%b",
                 j, pwm_sig, pwm_synch, mode_act, m_sig, m_synch, m_mode);
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge();
    test_duty_write();
    test_mode_switch();
    test_center();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator for the motor-drive path. A single shared WIDTH-bit period counter feeds CH independent duty comparators. Each channel's duty is double-buffered so that writes take effect only at a period boundary. A mode input selects edge-aligned (sawtooth) or center-aligned (triangle) modulation. A one-cycle synch pulse marks each period start for downstream sampling logic.

## Interface
- WIDTH, 11, counter and duty width in bits; MAX = 2^WIDTH-1
- CH, 2, number of PWM channels (>=1)
- CHW, $clog2(CH) (min 1), width of the channel-select field
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable
- mode  in  1  requested mode: 0 = edge-aligned, 1 = center-aligned
- wr_en  in  1  duty write strobe
- wr_ch  in  CHW  target channel for the write
- wr_duty  in  WIDTH  new duty value for the target channel
- pwm_sig  out  CH  registered PWM outputs, one bit per channel
- pwm_synch  out  1  registered one-cycle pulse at period start
- mode_act  out  1  mode currently in effect

## Operation
- State:
  - cnt[WIDTH]
  - dir (0 = up)
  - mode_act
  - shadow[CH][WIDTH]
  - active[CH][WIDTH]
  - pwm_sig
  - pwm_synch
- Reset: every state element and output clears to 0, so cnt = 0, dir = up, edge mode, all duties 0, pwm_sig = 0, pwm_synch = 0.
- Writes: wr_en with wr_ch < CH loads shadow[wr_ch] <= wr_duty. A write with wr_ch >= CH is ignored. Writes are accepted regardless of en.
- Edge mode counter: cnt counts 0..MAX, wraps MAX->0. Period = 2^WIDTH cycles.
- Center mode counter:
  - Sequence is 0,1,..,MAX,MAX-1,..,1,0,...
  - dir goes to down when cnt reaches MAX and to up when it reaches 0.
  - Period = 2*MAX cycles.
- period_end:
  - Edge mode: cnt == MAX.
  - Center mode: dir down and cnt == 1.
- On each period_end edge:
  - active[i] <= shadow[i] for all i.
  - mode_act <= mode.
  - If mode differs from mode_act, cnt -> 0 and dir -> up, which is the normal next value in both modes.
- A write in the same cycle as period_end lands in shadow only. The previous shadow value goes to active, and the new value applies at the next period_end.
- Channel compare: pwm_sig[i] <= en & (cnt < active[i]).
  - duty 0 gives a constant low output.
  - Edge mode: high cycles per period = duty. MAX gives 2^WIDTH-1 high cycles; 100% duty is unreachable by design.
  - Center mode: high cycles per period = 2*duty-1 for duty >= 1. The pulse is symmetric about cnt = 0.
- Synch: pwm_synch <= en & (cnt == 0). In center mode, cnt == 0 occurs exactly once per period.
- en low:
  - cnt holds at 0 and dir = up.
  - active[i] <= shadow[i] every cycle and mode_act <= mode every cycle.
  - pwm_sig and pwm_synch go to 0 on the next edge.
- en rising: counting starts from 0 with the shadow values already active. The first pwm_synch occurs on the edge after the first enabled cycle.

## Timing
- pwm_sig and pwm_synch are registered one cycle behind cnt, so the synch pulse coincides with the output cycle for cnt = 0.
- Write to output latency:
  - Write at edge t lands in shadow at t.
  - It is copied to active at the next period_end edge p > t.
  - Its effect appears on pwm_sig from edge p+1 onward.
- Mode change latency: identical to a duty write. mode is sampled only at period_end, or continuously while en is low.
- Asynchronous reset mid-period: everything clears immediately with no partial pulse. After release, edge mode restarts at cnt = 0.
- No combinational path exists from any input to any output.

## Test plan
- WIDTH=4, CH=2, edge mode, en=1:
  - Write duty 5 to ch0 and 12 to ch1.
  - After the first pwm_synch: ch0 high 5 of every 16 cycles, ch1 high 12 of 16.
  - pwm_synch is high exactly 1 of every 16 cycles, and both pwm_sig rise in the synch cycle.
- Center mode with ch0 duty 5:
  - Period 30 cycles; ch0 high 9 cycles, centered on the synch cycle.
  - Duty 0 gives a constant low output; duty 15 gives 29 high cycles of 30.
- Duty write mid-period (ch0 5 -> 9 at cnt = 7):
  - The current period still shows 5 high cycles; the next shows 9.
  - A write on the period_end cycle applies only one period later.
- Mode switch from edge to center mid-period: the edge period completes, then cnt restarts at 0 going up and mode_act changes at the same boundary.
- Out-of-range write (CH=3, wr_ch=3) leaves all shadows unchanged.
- Enable and reset:
  - en dropped mid-period: outputs low on the next edge and cnt held at 0.
  - en restored: first synch after 1 cycle, with new duty values live.
  - rst_n pulsed mid-pulse: pwm_sig, pwm_synch and mode_act read 0 immediately.
